subleq_sequencer: RTL and testbench

SUBLEQ_SEQUENCER -- requirements
Module: subleq_sequencer

---
 rtl/urisc_pkg.sv | 24 ++
 rtl/subleq_alu.sv | 14 +
 rtl/subleq_sequencer.sv | 109 ++++++++++
 tb/tb_subleq_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urisc_pkg.sv
// urisc_pkg: shared state encoding and constants for the SUBLEQ sequencer
package urisc_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam logic [ADDR_W_DEF-1:0] HALT_ADDR = '1;
   typedef enum logic [2:0] {
      FETCH_A,
      FETCH_B,
      FETCH_C,
      READ_A,
      READ_B,
      WRITE_B,
      BRANCH,
      HALTED
   } state_t;
   // Successor of a memory state once its transaction has been acknowledged
   function automatic state_t after_ack(input state_t s);
      return s == FETCH_A ? FETCH_B :
             s == FETCH_B ? FETCH_C :
             s == FETCH_C ? READ_A  :
             s == READ_A  ? READ_B  :
             s == READ_B  ? WRITE_B : BRANCH;
   endfunction
endpackage

// File: rtl/subleq_alu.sv
// subleq_alu: SUBLEQ subtract with signed not-positive test on the wrapped result
module subleq_alu
   import urisc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic              leq
);
   assign result = op_b - op_a;
   assign leq = result[DATA_W-1] | ~|result;
endmodule

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: multi-cycle SUBLEQ core issuing one memory transaction per phase strobe
module subleq_sequencer
   import urisc_pkg::*;
#(
   parameter int                PHASES   = 4,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clkIn,
   input  logic              rst,
   input  logic [PHASES-1:0] phaseIn,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic [ADDR_W-1:0] pc,
   output logic              halt,
   output logic              phaseErr
);
   // All-ones halt target, sign-extended so it stays all-ones for any ADDR_W
   localparam logic [ADDR_W-1:0] HALT_PC = ADDR_W'(signed'(HALT_ADDR));

   state_t state, state_n;
   logic [ADDR_W-1:0] a, b, c, a_n, b_n, c_n, pc_n, addr_n;
   logic [DATA_W-1:0] op_a, op_b, op_a_n, op_b_n, wdata_n, result;
   logic req_n, we_n, halt_n, leq, strobe, one_hot, take_halt;

   subleq_alu #(.DATA_W(DATA_W)) alu (
      .op_a  (op_a),
      .op_b  (op_b),
      .result(result),
      .leq   (leq)
   );

   assign strobe = phaseIn[0];
   assign one_hot = |phaseIn && ~|(phaseIn & (phaseIn - PHASES'(1)));
   assign take_halt = leq && c == HALT_PC;

   always_comb begin
      state_n = state;
      pc_n = pc;
      req_n = memReq;
      we_n = memWe;
      addr_n = memAddr;
      wdata_n = memWdata;
      a_n = a;
      b_n = b;
      c_n = c;
      op_a_n = op_a;
      op_b_n = op_b;
      halt_n = halt;
      if (memReq && memAck) begin
         req_n = 1'b0;
         state_n = after_ack(state);
         a_n = state == FETCH_A ? ADDR_W'(memRdata) : a;
         b_n = state == FETCH_B ? ADDR_W'(memRdata) : b;
         c_n = state == FETCH_C ? ADDR_W'(memRdata) : c;
         op_a_n = state == READ_A ? memRdata : op_a;
         op_b_n = state == READ_B ? memRdata : op_b;
      end else if (!memReq && strobe && state == BRANCH) begin
         state_n = take_halt ? HALTED : FETCH_A;
         halt_n = take_halt;
         pc_n = !leq ? pc + ADDR_W'(3) : take_halt ? pc : c;
      end else if (!memReq && strobe && state != HALTED) begin
         req_n = 1'b1;
         we_n = state == WRITE_B;
         wdata_n = result;
         addr_n = state == FETCH_A ? pc :
                  state == FETCH_B ? pc + ADDR_W'(1) :
                  state == FETCH_C ? pc + ADDR_W'(2) :
                  state == READ_A  ? a : b;
      end
   end

   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state <= FETCH_A;
         pc <= RESET_PC;
         memReq <= 1'b0;
         memWe <= 1'b0;
         memAddr <= '0;
         memWdata <= '0;
         a <= '0;
         b <= '0;
         c <= '0;
         op_a <= '0;
         op_b <= '0;
         halt <= 1'b0;
         phaseErr <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         memReq <= req_n;
         memWe <= we_n;
         memAddr <= addr_n;
         memWdata <= wdata_n;
         a <= a_n;
         b <= b_n;
         c <= c_n;
         op_a <= op_a_n;
         op_b <= op_b_n;
         halt <= halt_n;
         phaseErr <= phaseErr | ~one_hot;
      end
   end
endmodule

// File: tb/tb_subleq_sequencer.sv
// tb_subleq_sequencer: directed SUBLEQ scenarios checked against a transaction-level model
module tb_subleq_sequencer;
   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] pc;
   } txn_t;

   logic clkIn = 1'b0;
   logic rst = 1'b1;
   logic [3:0] phaseIn = 4'b0001;
   logic memReq, memWe, memAck, halt, phaseErr;
   logic [15:0] memAddr, memWdata, memRdata, pc;

   logic [15:0] img [64];
   logic [15:0] ram [64];
   logic [15:0] mm [64];
   logic [15:0] mpc = 16'h0;
   logic mhalt = 1'b0;
   logic prev_req = 1'b0;
   logic prev_we = 1'b0;
   logic [15:0] prev_addr = 16'h0;
   logic [15:0] prev_wdata = 16'h0;
   logic last_strobe = 1'b0;
   logic load = 1'b0;
   logic stray_ack = 1'b0;
   logic err_inj = 1'b0;
   int age = 0;
   int txn_cnt = 0;
   int delay_txn = -1;
   int delay_len = 0;
   int cyc = 0;
   int ph = 0;
   int n_cmp = 0;
   int n_bad = 0;
   txn_t expq[$];
   int issues[$];

   subleq_sequencer #(.PHASES(4), .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
      .clkIn   (clkIn),
      .rst     (rst),
      .phaseIn (phaseIn),
      .memReq  (memReq),
      .memWe   (memWe),
      .memAddr (memAddr),
      .memWdata(memWdata),
      .memRdata(memRdata),
      .memAck  (memAck),
      .pc      (pc),
      .halt    (halt),
      .phaseErr(phaseErr)
   );

   always #5 clkIn = ~clkIn;

   // Memory responder: ack after a per-transaction delay, plus an optional stray ack
   assign memAck = (memReq && age >= (txn_cnt == delay_txn ? delay_len : 0)) || stray_ack;
   assign memRdata = memAddr < 16'd64 ? ram[memAddr[5:0]] : 16'h0000;

   always @(posedge clkIn) begin
      if (load) for (int i = 0; i < 64; i++) ram[i] = img[i];
      else if (memReq && memAck && memWe && memAddr < 16'd64) ram[memAddr[5:0]] = memWdata;
      age <= memReq ? age + 1 : 0;
      txn_cnt <= rst ? 0 : txn_cnt + int'(memReq && memAck);
      last_strobe <= phaseIn[0];
      cyc <= cyc + 1;
   end

   initial forever begin
      @(negedge clkIn);
      phaseIn = (err_inj && ph == 0) ? 4'b0011 : 4'b0001 << ph;
      ph = (ph + 1) % 4;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rd(input logic [15:0] ad);
      return ad < 16'd64 ? mm[ad[5:0]] : 16'h0000;
   endfunction

   task automatic push(input logic we, input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] p);
      txn_t t;
      t.we = we;
      t.addr = ad;
      t.wdata = wd;
      t.pc = p;
      expq.push_back(t);
   endtask

   // Executes one SUBLEQ instruction on the model memory and queues its six bus transactions
   task automatic gen();
      logic [15:0] a, b, c, r;
      if (mhalt) return;
      a = rd(mpc);
      b = rd(mpc + 16'd1);
      c = rd(mpc + 16'd2);
      r = rd(b) - rd(a);
      push(1'b0, mpc, 16'h0, mpc);
      push(1'b0, mpc + 16'd1, 16'h0, mpc);
      push(1'b0, mpc + 16'd2, 16'h0, mpc);
      push(1'b0, a, 16'h0, mpc);
      push(1'b0, b, 16'h0, mpc);
      push(1'b1, b, r, mpc);
      if (b < 16'd64) mm[b[5:0]] = r;
      if ($signed(r) > 0) mpc = mpc + 16'd3;
      else if (c == 16'hFFFF) mhalt = 1'b1;
      else mpc = c;
   endtask

   // Per-cycle compare against the model, sampled on the falling edge
   task automatic tick();
      txn_t t;
      @(negedge clkIn);
      if (rst) begin
         for (int i = 0; i < 64; i++) mm[i] = img[i];
         mpc = 16'h0;
         mhalt = 1'b0;
         expq.delete();
         issues.delete();
         prev_req = 1'b0;
      end else begin
         if (memReq && !prev_req) begin
            chk("issue_on_strobe", 32'(last_strobe), 32'd1);
            issues.push_back(cyc);
         end
         if (memReq && prev_req) begin
            chk("hold_we", 32'(memWe), 32'(prev_we));
            chk("hold_addr", 32'(memAddr), 32'(prev_addr));
            chk("hold_wdata", 32'(memWdata), 32'(prev_wdata));
         end
         if (memReq && memAck) begin
            if (expq.size() == 0) gen();
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL txn_unexpected: request at addr %h, model expects none", memAddr);
            end else begin
               t = expq.pop_front();
               chk("txn_we", 32'(memWe), 32'(t.we));
               chk("txn_addr", 32'(memAddr), 32'(t.addr));
               if (t.we) chk("txn_wdata", 32'(memWdata), 32'(t.wdata));
               chk("txn_pc", 32'(pc), 32'(t.pc));
            end
         end
         prev_req = memReq;
         prev_we = memWe;
         prev_addr = memAddr;
         prev_wdata = memWdata;
      end
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_issues(input int n, input int limit, input string name);
      int k = 0;
      while (issues.size() < n && k < limit) begin
         tick();
         k++;
      end
      if (issues.size() < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: %0d requests seen, needed %0d", name, issues.size(), n);
      end
   endtask

   task automatic start(input logic [15:0] w0, w1, w2, w3, w4, w5);
      for (int i = 0; i < 64; i++) img[i] = 16'h0;
      img[0] = w0;
      img[1] = w1;
      img[2] = w2;
      img[3] = w3;
      img[4] = w4;
      img[5] = w5;
      rst = 1'b1;
      load = 1'b1;
      delay_txn = -1;
      cycles(2);
      load = 1'b0;
      chk("rst_req", 32'(memReq), 32'd0);
      chk("rst_we", 32'(memWe), 32'd0);
      chk("rst_addr", 32'(memAddr), 32'd0);
      chk("rst_wdata", 32'(memWdata), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_phase_err", 32'(phaseErr), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      int busy;
      // Positive result: mem[4] = 7-5 = 2, fall through to pc 3
      start(16'd3, 16'd4, 16'd6, 16'd5, 16'd7, 16'd0);
      wait_issues(7, 40, "s1_progress");
      if (issues.size() >= 7) begin
         chk("s1_span", 32'(issues[6] - issues[0]), 32'd28);
         chk("s1_step", 32'(issues[1] - issues[0]), 32'd4);
      end
      chk("s1_mem4", 32'(ram[4]), 32'd2);
      chk("s1_pc", 32'(pc), 32'd3);
      // Zero result branches: mem[4] = 0, pc 6
      start(16'd3, 16'd4, 16'd6, 16'd7, 16'd7, 16'd0);
      wait_issues(7, 40, "s2_progress");
      chk("s2_mem4", 32'(ram[4]), 32'd0);
      chk("s2_pc", 32'(pc), 32'd6);
      // READ_A acked six cycles late; the strobe in the middle is ignored
      start(16'd3, 16'd4, 16'd6, 16'd5, 16'd7, 16'd0);
      delay_txn = 3;
      delay_len = 6;
      wait_issues(4, 20, "s3_read_a");
      repeat (6) begin
         tick();
         chk("s3_req_held", 32'(memReq), 32'd1);
         chk("s3_addr_held", 32'(memAddr), 32'd3);
      end
      wait_issues(5, 12, "s3_read_b");
      if (issues.size() >= 5) chk("s3_gap", 32'(issues[4] - issues[3]), 32'd8);
      wait_issues(7, 40, "s3_progress");
      if (issues.size() >= 7) chk("s3_span", 32'(issues[6] - issues[0]), 32'd32);
      chk("s3_mem4", 32'(ram[4]), 32'd2);
      chk("s3_pc", 32'(pc), 32'd3);
      // Taken branch to all-ones halts with pc held
      start(16'd3, 16'd3, 16'hFFFF, 16'd5, 16'd0, 16'd0);
      wait_issues(6, 30, "s4_progress");
      cycles(6);
      chk("s4_halt", 32'(halt), 32'd1);
      chk("s4_pc", 32'(pc), 32'd0);
      chk("s4_mem3", 32'(ram[3]), 32'd0);
      busy = 0;
      repeat (40) begin
         tick();
         busy += int'(memReq);
      end
      chk("s4_idle", 32'(busy), 32'd0);
      chk("s4_halt_sticky", 32'(halt), 32'd1);
      chk("s4_pc_held", 32'(pc), 32'd0);
      // Reset while the write is outstanding, then a stray ack
      start(16'd3, 16'd4, 16'd6, 16'd5, 16'd7, 16'd0);
      delay_txn = 5;
      delay_len = 30;
      wait_issues(6, 40, "s5_write");
      cycles(2);
      chk("s5_wr_req", 32'(memReq), 32'd1);
      chk("s5_wr_we", 32'(memWe), 32'd1);
      chk("s5_wr_addr", 32'(memAddr), 32'd4);
      chk("s5_wr_data", 32'(memWdata), 32'd2);
      rst = 1'b1;
      #1;
      chk("s5_rst_req", 32'(memReq), 32'd0);
      chk("s5_rst_we", 32'(memWe), 32'd0);
      chk("s5_rst_addr", 32'(memAddr), 32'd0);
      chk("s5_rst_pc", 32'(pc), 32'd0);
      delay_txn = -1;
      tick();
      rst = 1'b0;
      stray_ack = 1'b1;
      @(posedge clkIn);
      #1;
      stray_ack = 1'b0;
      chk("s5_no_write", 32'(ram[4]), 32'd7);
      wait_issues(1, 6, "s5_restart");
      chk("s5_first_addr", 32'(memAddr), 32'd0);
      chk("s5_first_we", 32'(memWe), 32'd0);
      wait_issues(7, 40, "s5_progress");
      chk("s5_mem4", 32'(ram[4]), 32'd2);
      chk("s5_pc", 32'(pc), 32'd3);
      // Non-one-hot phase vector for one cycle sets a sticky flag only
      start(16'd3, 16'd4, 16'd6, 16'd5, 16'd7, 16'd0);
      wait_issues(1, 6, "s6_start");
      chk("s6_err_clear", 32'(phaseErr), 32'd0);
      err_inj = 1'b1;
      cycles(4);
      err_inj = 1'b0;
      cycles(1);
      chk("s6_err_set", 32'(phaseErr), 32'd1);
      wait_issues(7, 40, "s6_progress");
      if (issues.size() >= 7) chk("s6_span", 32'(issues[6] - issues[0]), 32'd28);
      chk("s6_mem4", 32'(ram[4]), 32'd2);
      chk("s6_pc", 32'(pc), 32'd3);
      chk("s6_err_sticky", 32'(phaseErr), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
